// File: rtl/draw_pkg.sv
// Framebuffer geometry defaults shared by the drawing engines and the
// framebuffer write stage.
package draw_pkg;

    localparam int CORDW     = 10;
    localparam int COLRW     = 4;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 180;
    localparam int ADDRW     = 16;

endpackage

// File: rtl/fifo_sync.sv
// Show-ahead synchronous FIFO: dout presents the head entry whenever !empty,
// and a push into a full FIFO is accepted if a pop happens in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam int            DEPTH_I  = DEPTH;
    localparam logic [AW:0]   FULL_CNT = DEPTH_I[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

endmodule

// File: rtl/draw_fb_writer.sv
// Framebuffer write stage: clips the drawing engine's pixel stream, converts
// pixels to linear addresses and queues them for a valid/ready memory port.
module draw_fb_writer #(
    parameter int CORDW      = draw_pkg::CORDW,
    parameter int COLRW      = draw_pkg::COLRW,
    parameter int FB_WIDTH   = draw_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = draw_pkg::FB_HEIGHT,
    parameter int ADDRW      = draw_pkg::ADDRW,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drawing,
    input  logic [CORDW-1:0] x,
    input  logic [CORDW-1:0] y,
    input  logic [COLRW-1:0] colr,
    output logic             oe,
    output logic             fb_we,
    output logic [ADDRW-1:0] fb_addr,
    output logic [COLRW-1:0] fb_colr,
    input  logic             fb_ready,
    output logic             idle
);

    localparam int             CNTW       = $clog2(FIFO_DEPTH) + 1;
    localparam int             FIFOW      = ADDRW + COLRW;
    localparam int             OE_LIMIT_I = FIFO_DEPTH - 4;
    localparam logic [CNTW:0]  OE_LIMIT   = OE_LIMIT_I[CNTW:0];

    logic             in_bounds;
    logic             s1_valid;
    logic [CORDW-1:0] s1_x;
    logic [CORDW-1:0] s1_y;
    logic [COLRW-1:0] s1_colr;
    logic             s2_valid;
    logic [ADDRW-1:0] s2_addr;
    logic [COLRW-1:0] s2_colr;
    logic [FIFOW-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic [CNTW-1:0]  fifo_count;
    logic [CNTW:0]    occ;

    assign in_bounds = (32'(x) < FB_WIDTH) && (32'(y) < FB_HEIGHT);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= drawing && in_bounds;
        end
        s1_x    <= x;
        s1_y    <= y;
        s1_colr <= colr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        s2_addr <= ADDRW'(s1_y) * ADDRW'(FB_WIDTH) + ADDRW'(s1_x);
        s2_colr <= s1_colr;
    end

    fifo_sync #(
        .WIDTH (FIFOW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .pop   (fifo_pop),
        .din   ({s2_addr, s2_colr}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign fb_we    = !fifo_empty;
    assign fifo_pop = fb_we && fb_ready;
    assign fb_addr  = fifo_dout[FIFOW-1:COLRW];
    assign fb_colr  = fifo_dout[COLRW-1:0];
    assign idle     = !s1_valid && !s2_valid && fifo_empty;

    // Pixels already in the pipeline are counted so the registered oe can
    // lag by a cycle and the FIFO still never overflows.
    assign occ = (CNTW+1)'(fifo_count) + (CNTW+1)'(s1_valid) + (CNTW+1)'(s2_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            oe <= 1'b0;
        end else begin
            oe <= (occ <= OE_LIMIT);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(s2_valid && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_draw_fb_writer.sv
// Directed bench for draw_fb_writer: single-pixel vector table plus burst,
// backpressure, random-ready rectangle and mid-stream reset sequences.
module tb_draw_fb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drawing = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [3:0]  colr = '0;
    logic        fb_ready = 1'b0;
    logic        oe;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [3:0]  fb_colr;
    logic        idle;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    logic [15:0] wr_addr_q[$];
    logic [3:0]  wr_colr_q[$];
    int          wr_cyc_q[$];
    logic [15:0] exp_addr_q[$];
    logic [3:0]  exp_colr_q[$];

    typedef struct {
        logic        drawing;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  colr;
        logic        exp_we;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl[9];

    draw_fb_writer dut (
        .clk      (clk),
        .rst      (rst),
        .drawing  (drawing),
        .x        (x),
        .y        (y),
        .colr     (colr),
        .oe       (oe),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_colr  (fb_colr),
        .fb_ready (fb_ready),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are logged mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        if (!rst && fb_we && fb_ready) begin
            wr_addr_q.push_back(fb_addr);
            wr_colr_q.push_back(fb_colr);
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] pixAddr(input int px, input int py);
        return 16'(py * 320 + px);
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
        if (rand_ready) fb_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic d, input logic [9:0] px, input logic [9:0] py,
                                 input logic [3:0] pc);
        drawing = d;
        x = px;
        y = py;
        colr = pc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearQueues();
        wr_addr_q.delete();
        wr_colr_q.delete();
        wr_cyc_q.delete();
        exp_addr_q.delete();
        exp_colr_q.delete();
    endtask

    // Holds the previous pixel for its cycle, then drives the new one as
    // soon as oe allows it.
    task automatic streamPixel(input int px, input int py, input logic [3:0] pc);
        int waited = 0;
        nextCycle();
        while (!oe && waited < 100) begin
            applyStimulus(1'b0, '0, '0, '0);
            nextCycle();
            waited++;
        end
        if (!oe) checkOutput("stream_oe_timeout", 32'(oe), 32'd1);
        applyStimulus(1'b1, 10'(px), 10'(py), pc);
        exp_addr_q.push_back(pixAddr(px, py));
        exp_colr_q.push_back(pc);
    endtask

    task automatic endStream();
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (!idle && n < budget) begin
            nextCycle();
            n++;
        end
        checkOutput(name, 32'(idle), 32'd1);
    endtask

    task automatic compareWrites(input string tag);
        checkOutput({tag, "_count"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
            checkOutput({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
            checkOutput({tag, "_colr"}, 32'(wr_colr_q[i]), 32'(exp_colr_q[i]));
        end
    endtask

    initial begin
        int start_cyc;
        int sent;
        int stall;
        bit saw_low;

        tbl[0] = '{1'b1, 10'd5,    10'd2,    4'd3,  1'b1, 16'd645};
        tbl[1] = '{1'b1, 10'd319,  10'd179,  4'd7,  1'b1, 16'd57599};
        tbl[2] = '{1'b1, 10'd0,    10'd0,    4'd15, 1'b1, 16'd0};
        tbl[3] = '{1'b1, 10'd320,  10'd0,    4'd2,  1'b0, 16'd0};
        tbl[4] = '{1'b1, 10'd0,    10'd180,  4'd2,  1'b0, 16'd0};
        tbl[5] = '{1'b1, 10'd1023, 10'd1023, 4'd6,  1'b0, 16'd0};
        tbl[6] = '{1'b1, 10'd319,  10'd0,    4'd9,  1'b1, 16'd319};
        tbl[7] = '{1'b1, 10'd0,    10'd179,  4'd1,  1'b1, 16'd57280};
        tbl[8] = '{1'b0, 10'd5,    10'd5,    4'd4,  1'b0, 16'd0};

        // Reset state and oe release
        fb_ready = 1'b1;
        repeat (3) nextCycle();
        checkOutput("rst_oe", 32'(oe), 32'd0);
        checkOutput("rst_we", 32'(fb_we), 32'd0);
        checkOutput("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        nextCycle();
        checkOutput("rst_oe_rise", 32'(oe), 32'd1);

        // Single-pixel latency, clipping and address table
        foreach (tbl[i]) begin
            nextCycle();
            applyStimulus(tbl[i].drawing, tbl[i].x, tbl[i].y, tbl[i].colr);
            nextCycle();
            applyStimulus(1'b0, '0, '0, '0);
            checkOutput("vec_we_n1", 32'(fb_we), 32'd0);
            if (!tbl[i].exp_we) checkOutput("vec_idle_n1", 32'(idle), 32'd1);
            nextCycle();
            checkOutput("vec_we_n2", 32'(fb_we), 32'd0);
            if (!tbl[i].exp_we) checkOutput("vec_idle_n2", 32'(idle), 32'd1);
            nextCycle();
            checkOutput("vec_we_n3", 32'(fb_we), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we) begin
                checkOutput("vec_addr", 32'(fb_addr), 32'(tbl[i].exp_addr));
                checkOutput("vec_colr", 32'(fb_colr), 32'(tbl[i].colr));
            end
            nextCycle();
            checkOutput("vec_we_n4", 32'(fb_we), 32'd0);
            checkOutput("vec_idle_n4", 32'(idle), 32'd1);
        end

        // Full-rate burst along the bottom row
        clearQueues();
        nextCycle();
        start_cyc = cyc;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 10'(i), 10'd179, 4'(i));
            exp_addr_q.push_back(pixAddr(i, 179));
            exp_colr_q.push_back(4'(i));
            checkOutput("burst_oe", 32'(oe), 32'd1);
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, '0);
        waitIdle("burst_idle", 20);
        compareWrites("burst");
        for (int i = 0; i < wr_cyc_q.size(); i++) begin
            checkOutput("burst_cycle", 32'(wr_cyc_q[i]), 32'(start_cyc + 3 + i));
        end

        // Backpressure: stall the port, then release it mid-stream
        clearQueues();
        fb_ready = 1'b0;
        sent = 0;
        stall = 0;
        saw_low = 1'b0;
        while (sent < 20 && stall < 300) begin
            nextCycle();
            stall++;
            if (!oe) saw_low = 1'b1;
            if (!fb_ready && fb_we) begin
                checkOutput("bp_hold_addr", 32'(fb_addr), 32'd3200);
                checkOutput("bp_hold_colr", 32'(fb_colr), 32'd0);
            end
            if (stall == 16) begin
                checkOutput("bp_stall_we", 32'(fb_we), 32'd1);
                fb_ready = 1'b1;
            end
            if (oe) begin
                applyStimulus(1'b1, 10'(sent), 10'd10, 4'(sent));
                exp_addr_q.push_back(pixAddr(sent, 10));
                exp_colr_q.push_back(4'(sent));
                sent++;
            end else begin
                applyStimulus(1'b0, '0, '0, '0);
            end
        end
        endStream();
        waitIdle("bp_idle", 50);
        checkOutput("bp_oe_fell", 32'(saw_low), 32'd1);
        compareWrites("bp");

        // Filled 10x10 rectangle at (100,50) with random fb_ready
        clearQueues();
        rand_ready = 1'b1;
        for (int yy = 50; yy < 60; yy++) begin
            for (int xx = 100; xx < 110; xx++) begin
                streamPixel(xx, yy, 4'((xx + yy) % 16));
            end
        end
        endStream();
        waitIdle("rect_idle", 500);
        rand_ready = 1'b0;
        fb_ready = 1'b1;
        compareWrites("rect");

        // Reset with three pixels queued and two in flight
        clearQueues();
        fb_ready = 1'b0;
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 10'(20 + i), 10'd30, 4'd5);
            checkOutput("mid_oe", 32'(oe), 32'd1);
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("mid_queued_we", 32'(fb_we), 32'd1);
        checkOutput("mid_busy", 32'(idle), 32'd0);
        rst = 1'b1;
        nextCycle();
        checkOutput("mid_rst_we", 32'(fb_we), 32'd0);
        checkOutput("mid_rst_idle", 32'(idle), 32'd1);
        checkOutput("mid_rst_oe", 32'(oe), 32'd0);
        rst = 1'b0;
        fb_ready = 1'b1;
        nextCycle();
        checkOutput("mid_oe_rise", 32'(oe), 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("mid_no_we", 32'(fb_we), 32'd0);
            nextCycle();
        end
        checkOutput("mid_stale_writes", 32'(wr_addr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
